// File: rtl/pong_if.sv
`timescale 1ns/1ps
// pong_if: bundle between the game logic and the VGA renderer.
//   sq_xpos/sq_ypos         : square top-left corner
//   pdl1_xpos/pdl1_ypos     : left paddle top-left corner
//   pdl2_xpos/pdl2_ypos     : right paddle top-left corner
//   hsync/vsync             : active-low sync pulses
//   video_on                : registered pixel lies in the active area
//   red/green/blue          : 4-bit colour per channel
//   frame_tick              : one-cycle pulse at vblank start
// master = game logic side (drives coordinates), slave = renderer side.
interface pong_if;
  logic [9:0] sq_xpos;
  logic [9:0] sq_ypos;
  logic [9:0] pdl1_xpos;
  logic [9:0] pdl1_ypos;
  logic [9:0] pdl2_xpos;
  logic [9:0] pdl2_ypos;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       frame_tick;

  modport master (
    output sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos,
    input  hsync, vsync, video_on, red, green, blue, frame_tick
  );

  modport slave (
    input  sq_xpos, sq_ypos, pdl1_xpos, pdl1_ypos, pdl2_xpos, pdl2_ypos,
    output hsync, vsync, video_on, red, green, blue, frame_tick
  );
endinterface

// File: rtl/pong_renderer.sv
`timescale 1ns/1ps
// pong_renderer: VGA timing generator and sprite compositor for pong.
// Ports:
//   clk_0 : pixel clock (25 MHz for 640x480@60)
//   rst   : asynchronous, active-high reset
//   bus   : pong_if.slave -- sprite coordinates in, sync/video/RGB/frame_tick out
// The coordinates are copied into shadow registers once per frame at vblank
// start, so a frame is always drawn from one consistent set of positions.
// Every output is registered once from combinational stage-0 values, so all
// outputs lag the counters by one clock and stay aligned with each other.
module pong_renderer #(
  parameter int         H_VIDEO    = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_VIDEO    = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter int         SQ_WIDTH   = 16,
  parameter int         PDL_WIDTH  = 12,
  parameter int         PDL_HEIGHT = 96,
  parameter int         NET_X      = 319,
  parameter logic [3:0] NET_COLOR  = 4'h8
) (
  input  logic   clk_0,
  input  logic   rst,
  pong_if.slave  bus
);

  localparam logic [9:0]  H_MAX  = 10'(H_VIDEO + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_MAX  = 10'(V_VIDEO + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_ACT  = 10'(H_VIDEO);
  localparam logic [9:0]  V_ACT  = 10'(V_VIDEO);
  localparam logic [9:0]  HS_BEG = 10'(H_VIDEO + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_VIDEO + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG = 10'(V_VIDEO + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_VIDEO + V_FP + V_SYNC);
  localparam logic [9:0]  NET_L  = 10'(NET_X);
  localparam logic [9:0]  NET_R  = 10'(NET_X + 1);
  localparam logic [10:0] SQ_SPAN = 11'(SQ_WIDTH - 1);
  localparam logic [10:0] PW_SPAN = 11'(PDL_WIDTH - 1);
  localparam logic [10:0] PH_SPAN = 11'(PDL_HEIGHT - 1);

  localparam logic [9:0] SQ_X_RST   = 10'd320;
  localparam logic [9:0] SQ_Y_RST   = 10'd240;
  localparam logic [9:0] PDL1_X_RST = 10'd24;
  localparam logic [9:0] PDL1_Y_RST = 10'd191;
  localparam logic [9:0] PDL2_X_RST = 10'd603;
  localparam logic [9:0] PDL2_Y_RST = 10'd191;

  // Inclusive range test done in 11 bits so base+span near 1023 cannot wrap
  // back onto low coordinates.
  function automatic logic in_span(input logic [9:0]  pos,
                                   input logic [9:0]  base,
                                   input logic [10:0] span);
    logic [10:0] p;
    logic [10:0] lo;
    p  = {1'b0, pos};
    lo = {1'b0, base};
    return (p >= lo) && (p <= (lo + span));
  endfunction

  // Square and paddles share full white; the net only shows where no sprite is.
  function automatic logic [3:0] pixel_level(input logic active,
                                             input logic sq_hit,
                                             input logic pdl_hit,
                                             input logic net_hit);
    if (!active)           return 4'h0;
    if (sq_hit || pdl_hit) return 4'hF;
    if (net_hit)           return NET_COLOR;
    return 4'h0;
  endfunction

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [9:0] sq_x_q, sq_y_q, p1_x_q, p1_y_q, p2_x_q, p2_y_q;
  logic       hsync_q, vsync_q, video_on_q, frame_tick_q;
  logic [3:0] rgb_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_MAX) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_MAX) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  // ---- stage 0: combinational decode of the counters ----
  logic       active_p0, hs_n_p0, vs_n_p0, snap_p0;
  logic       sq_hit_p0, pdl_hit_p0, net_hit_p0;
  logic [3:0] level_p0;

  assign active_p0  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_n_p0    = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs_n_p0    = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign snap_p0    = (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT);
  assign sq_hit_p0  = in_span(h_cnt_q, sq_x_q, SQ_SPAN) && in_span(v_cnt_q, sq_y_q, SQ_SPAN);
  assign pdl_hit_p0 = (in_span(h_cnt_q, p1_x_q, PW_SPAN) && in_span(v_cnt_q, p1_y_q, PH_SPAN)) ||
                      (in_span(h_cnt_q, p2_x_q, PW_SPAN) && in_span(v_cnt_q, p2_y_q, PH_SPAN));
  // 16-line dashes: bit 4 of the line number toggles every 16 lines.
  assign net_hit_p0 = ((h_cnt_q == NET_L) || (h_cnt_q == NET_R)) && !v_cnt_q[4];
  assign level_p0   = pixel_level(active_p0, sq_hit_p0, pdl_hit_p0, net_hit_p0);

  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Shadow copy of the coordinates; the value present on the snapshot
  // cycle itself is the one captured.
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      sq_x_q <= SQ_X_RST;
      sq_y_q <= SQ_Y_RST;
      p1_x_q <= PDL1_X_RST;
      p1_y_q <= PDL1_Y_RST;
      p2_x_q <= PDL2_X_RST;
      p2_y_q <= PDL2_Y_RST;
    end else if (snap_p0) begin
      sq_x_q <= bus.sq_xpos;
      sq_y_q <= bus.sq_ypos;
      p1_x_q <= bus.pdl1_xpos;
      p1_y_q <= bus.pdl1_ypos;
      p2_x_q <= bus.pdl2_xpos;
      p2_y_q <= bus.pdl2_ypos;
    end
  end

  // ---- stage 1: registered outputs ----
  always_ff @(posedge clk_0 or posedge rst) begin
    if (rst) begin
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      rgb_q        <= 4'h0;
      frame_tick_q <= 1'b0;
    end else begin
      hsync_q      <= hs_n_p0;
      vsync_q      <= vs_n_p0;
      video_on_q   <= active_p0;
      rgb_q        <= level_p0;
      frame_tick_q <= snap_p0;
    end
  end

  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.video_on   = video_on_q;
  assign bus.red        = rgb_q;
  assign bus.green      = rgb_q;
  assign bus.blue       = rgb_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
